// File: rtl/fir_pkg.sv
// Shared constants, state encoding and counter helper for the FIR window front end.
package fir_pkg;

    localparam int TAPS     = 10;
    localparam int DW       = 4;
    localparam int FILT_LAT = 2;
    localparam int Y_W      = 11;
    localparam int CNT_W    = 4;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        logic [CNT_W-1:0] r;
        if (v >= lim) begin
            r = lim;
        end else begin
            r = v + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fir_valid_delay.sv
// LAT-stage shift register that carries a valid strobe alongside a pipelined datapath.
module fir_valid_delay #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic in_valid,
    output logic out_valid
);

    logic [LAT-1:0] pipe_q;
    logic [LAT-1:0] pipe_d;

    // Shift the strobe one stage per cycle.
    always_comb begin
        pipe_d    = pipe_q;
        pipe_d[0] = in_valid;
        for (int i = 1; i < LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    // Pipeline register, cleared by async reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_q <= {LAT{1'b0}};
        end else begin
            pipe_q <= pipe_d;
        end
    end

    assign out_valid = pipe_q[LAT-1];

endmodule

// File: rtl/fir_window_feeder.sv
// Serial-to-parallel tap delay line with window strobe, decimation and flush/drain
// for the 10-tap parallel FIR datapath.
module fir_window_feeder
    import fir_pkg::*;
#(
    parameter int DECIM = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    input  logic          flush,
    output logic [DW-1:0] x_0,
    output logic [DW-1:0] x_1,
    output logic [DW-1:0] x_2,
    output logic [DW-1:0] x_3,
    output logic [DW-1:0] x_4,
    output logic [DW-1:0] x_5,
    output logic [DW-1:0] x_6,
    output logic [DW-1:0] x_7,
    output logic [DW-1:0] x_8,
    output logic [DW-1:0] x_9,
    output logic          win_valid,
    output logic          y_valid,
    output logic [3:0]    fill_cnt
);

    localparam int DCW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int DRW = (FILT_LAT > 1) ? $clog2(FILT_LAT) : 1;
    localparam logic [DCW-1:0]   DECIM_LAST = DCW'(DECIM - 1);
    localparam logic [DCW-1:0]   DECIM_ONE  = DCW'(1);
    localparam logic [DRW-1:0]   DRAIN_LOAD = DRW'(FILT_LAT - 1);
    localparam logic [DRW-1:0]   DRAIN_ONE  = DRW'(1);
    localparam logic [CNT_W-1:0] TAPS_CNT   = CNT_W'(TAPS);

    state_e           state_q, state_d;
    logic [DW-1:0]    x_q [TAPS];
    logic [DW-1:0]    x_d [TAPS];
    logic             win_valid_q, win_valid_d;
    logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [DCW-1:0]   decim_cnt_q, decim_cnt_d;
    logic [DRW-1:0]   drain_cnt_q, drain_cnt_d;
    logic             accept_s;

    assign s_ready  = (state_q != DRAIN) && !flush;
    assign accept_s = s_valid && s_ready;

    // Next-state, delay-line shift and window strobe generation.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        win_valid_d = 1'b0;
        fill_cnt_d  = fill_cnt_q;
        decim_cnt_d = decim_cnt_q;
        drain_cnt_d = drain_cnt_q;
        if (flush) begin
            // Flush overrides everything, including a flush already draining.
            state_d     = DRAIN;
            fill_cnt_d  = {CNT_W{1'b0}};
            decim_cnt_d = {DCW{1'b0}};
            drain_cnt_d = DRAIN_LOAD;
            for (int k = 0; k < TAPS; k++) begin
                x_d[k] = {DW{1'b0}};
            end
        end else begin
            if (accept_s) begin
                x_d[0] = s_data;
                for (int k = 1; k < TAPS; k++) begin
                    x_d[k] = x_q[k-1];
                end
            end else begin
                x_d = x_q;
            end
            case (state_q)
                FILL: begin
                    if (accept_s) begin
                        fill_cnt_d = sat_inc(fill_cnt_q, TAPS_CNT);
                        if (fill_cnt_q == (TAPS_CNT - 4'd1)) begin
                            state_d     = RUN;
                            decim_cnt_d = {DCW{1'b0}};
                            win_valid_d = 1'b1;
                        end else begin
                            state_d = FILL;
                        end
                    end else begin
                        state_d = FILL;
                    end
                end
                RUN: begin
                    if (accept_s) begin
                        if (decim_cnt_q == DECIM_LAST) begin
                            decim_cnt_d = {DCW{1'b0}};
                            win_valid_d = 1'b1;
                        end else begin
                            decim_cnt_d = decim_cnt_q + DECIM_ONE;
                        end
                    end else begin
                        decim_cnt_d = decim_cnt_q;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_q == {DRW{1'b0}}) begin
                        state_d = FILL;
                    end else begin
                        drain_cnt_d = drain_cnt_q - DRAIN_ONE;
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= FILL;
            win_valid_q <= 1'b0;
            fill_cnt_q  <= {CNT_W{1'b0}};
            decim_cnt_q <= {DCW{1'b0}};
            drain_cnt_q <= {DRW{1'b0}};
            for (int k = 0; k < TAPS; k++) begin
                x_q[k] <= {DW{1'b0}};
            end
        end else begin
            state_q     <= state_d;
            win_valid_q <= win_valid_d;
            fill_cnt_q  <= fill_cnt_d;
            decim_cnt_q <= decim_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            x_q         <= x_d;
        end
    end

    fir_valid_delay #(
        .LAT(FILT_LAT)
    ) u_valid_delay (
        .clk      (clk),
        .reset    (reset),
        .in_valid (win_valid_q),
        .out_valid(y_valid)
    );

    assign win_valid = win_valid_q;
    assign fill_cnt  = fill_cnt_q;
    assign x_0 = x_q[0];
    assign x_1 = x_q[1];
    assign x_2 = x_q[2];
    assign x_3 = x_q[3];
    assign x_4 = x_q[4];
    assign x_5 = x_q[5];
    assign x_6 = x_q[6];
    assign x_7 = x_q[7];
    assign x_8 = x_q[8];
    assign x_9 = x_q[9];

endmodule

// File: doc/fir_window_feeder.md
Name: fir_window_feeder

Overview:
Front-end stage for the 10-tap parallel FIR datapath. It accepts a serial stream of 4-bit samples over a valid/ready handshake and keeps a 10-deep tap delay line. It presents the window as parallel outputs x_0..x_9 to the filter, with a window strobe, and delays that strobe by the filter latency so y_valid lines up with the filter's registered 11-bit y. Decimation and a flush/drain sequence are supported.

Parameters:
TAPS, 10, delay-line depth (number of parallel x outputs)
DW, 4, sample width
FILT_LAT, 2, cycles from x_* change to registered y (product register + sum register)
DECIM, 1, emit one window per DECIM accepted samples in RUN (DECIM >= 1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
s_valid  in  1  upstream sample valid
s_data  in  DW  upstream sample
s_ready  out  1  feeder can accept; combinational = (state != DRAIN) && !flush
flush  in  1  one-cycle request: discard window and drain filter pipeline
x_0..x_9  out  DW each  window; x_0 newest, x_9 oldest; registered
win_valid  out  1  registered; high while x_* hold a newly emitted window
y_valid  out  1  win_valid delayed FILT_LAT cycles; qualifies filter y
fill_cnt  out  4  accepted samples in current fill, saturates at TAPS

Behaviour:
- Reset (async): x_* = 0, win_valid = 0, y_valid = 0 (whole delay pipe cleared), fill_cnt = 0, decim_cnt = 0, drain_cnt = 0, state = FILL. s_ready = 1 once flush is low.
- Accept = s_valid && s_ready at a rising edge. On accept: x_0 <= s_data, x_k <= x_(k-1) for k = 1..TAPS-1. With no accept, x_* hold.
- States:
  FILL: each accept increments fill_cnt. The accept that makes fill_cnt reach TAPS moves to RUN, clears decim_cnt, and sets win_valid for the following cycle.
  RUN: each accept increments decim_cnt. When decim_cnt == DECIM-1, the same edge wraps decim_cnt to 0 and sets win_valid for one cycle. With DECIM = 1, every accept emits a window.
  DRAIN: entered from any state on flush. That edge clears x_*, fill_cnt, decim_cnt and win_valid, and loads drain_cnt = FILT_LAT-1. drain_cnt decrements each cycle. At 0 the state returns to FILL. s_ready = 0 throughout DRAIN.
- win_valid is a 1-cycle pulse. It is never high for two consecutive cycles unless accepts occur on consecutive edges.
- Latency: accept at edge E0 -> x_* and win_valid valid in cycle after E0 -> y_valid high in cycle after E0+FILT_LAT.
- y_valid pipe keeps shifting in DRAIN and after a flush. Windows emitted before the flush still produce their y_valid.
- Flush and s_valid in the same cycle: flush wins. s_ready is low, so the sample is not accepted and upstream must hold it.
- Flush during DRAIN restarts drain_cnt.
- s_valid low in RUN: x_* hold, no win_valid. The filter's y stays constant but y_valid stays low.
- fill_cnt reads TAPS in RUN and 0 after flush.
- Samples are unsigned DW bits, with no arithmetic here. Downstream y width (11 bits) is unaffected.

Decomposition:
- Shared package fir_pkg: TAPS, DW, FILT_LAT, Y_W = 11, state encoding {FILL, RUN, DRAIN} as a 2-bit localparam set.
- Sub-module fir_valid_delay (parameter LAT, async reset to 0): FILT_LAT-stage shift register carrying win_valid to y_valid. It is reusable on the filter's output side.

Test Plan:
- Reset then accept samples 1..10 on consecutive edges -> fill_cnt 1..10; after 10th accept x_0=10 ... x_9=1, win_valid=1 for exactly 1 cycle; y_valid=1 exactly 2 cycles later; no win_valid before the 10th accept.
- DECIM=1, RUN, feed 11,12,13 back-to-back -> 3 consecutive win_valid cycles; after last accept x_0=13, x_1=12, x_2=11, x_9=4; y_valid 3 cycles long, offset by 2.
- DECIM=3, RUN, feed 6 samples with s_valid gaps -> win_valid only after the 3rd and 6th accepts; x_* unchanged during gaps.
- Flush in the same cycle as s_valid=1 (s_data=7) in RUN -> s_ready=0, 7 not accepted; next cycle x_*=0, fill_cnt=0, s_ready=0 for 2 cycles; pending y_valid from the previous window still appears; then FILL with s_ready=1.
- Assert reset asynchronously mid-RUN between edges -> x_*, win_valid, y_valid drop to 0 immediately; after release, 10 fresh samples are needed before any win_valid.
- Flush again on the 2nd DRAIN cycle -> DRAIN extended by a full FILT_LAT from the new flush; exactly one return to FILL.
